// File: rtl/shiftreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// FSM state type and small mode-decode helpers.
package shiftreg_pkg;

    // Mode encodings carried on the 2-bit mode input
    localparam logic [1:0] MODE_SHR = 2'b00;  // shift right, fill from sin
    localparam logic [1:0] MODE_SHL = 2'b01;  // shift left, fill from sin
    localparam logic [1:0] MODE_ROR = 2'b10;  // rotate right
    localparam logic [1:0] MODE_ROL = 2'b11;  // rotate left

    // Burst controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True when the mode moves data towards the MSB
    function automatic logic mode_is_left(input logic [1:0] m);
        return (m == MODE_SHL) || (m == MODE_ROL);
    endfunction

    // True when the bit leaving the register re-enters at the other end
    function automatic logic mode_is_rotate(input logic [1:0] m);
        return (m == MODE_ROR) || (m == MODE_ROL);
    endfunction

endpackage : shiftreg_pkg

// File: rtl/shift_counter.sv
// Loadable down-counter with clock enable. zero_o reports whether the count
// will be zero once the current edge is taken, which lets the controller
// leave SHIFT on the same edge as the final step.
module shift_counter #(
    parameter int COUNT_W = 3
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               enable_i,
    input  logic               load_i,
    input  logic [COUNT_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; decrement saturates at zero
    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - COUNT_W'(1);
        end
    end

    // Count register: synchronous clear, frozen while enable is low
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (clear) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_d == '0);

endmodule : shift_counter

// File: rtl/shiftreg_universal.sv
// Universal shift register: parallel load, counted shift/rotate bursts with
// serial in/out, busy/done handshake and a capture register for reads.
// Build option: define SHIFTREG_ROTATE_EN to enable rotate modes 10/11;
// without it those modes fall back to the plain shifts 00/01.
module shiftreg_universal
    import shiftreg_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 3
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               enable,
    input  logic               load,
    input  logic [WIDTH-1:0]   d,
    input  logic               start,
    input  logic [COUNT_W-1:0] count,
    input  logic [1:0]         mode,
    input  logic               sin,
    input  logic               read,
    output logic [WIDTH-1:0]   q,
    output logic               sout,
    output logic               busy,
    output logic               done
);

    state_t           state_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic             sout_q;
    logic [1:0]       mode_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] r_step_d;
    logic             sout_step_d;
    logic             fill_right;
    logic             fill_left;
    logic             cmd_window;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    // Commands are only honoured outside a running burst
    assign cmd_window = (state_q != ST_SHIFT);
    assign cnt_load   = cmd_window && start && !load;
    assign cnt_dec    = (state_q == ST_SHIFT);

    shift_counter #(
        .COUNT_W (COUNT_W)
    ) u_counter (
        .clk        (clk),
        .clear      (clear),
        .enable_i   (enable),
        .load_i     (cnt_load),
        .load_val_i (count),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // One shift/rotate step of the data register using the latched mode
    always_comb begin
        fill_right = sin;
        fill_left  = sin;
`ifdef SHIFTREG_ROTATE_EN
        if (mode_is_rotate(mode_q)) begin
            fill_right = r_q[0];
            fill_left  = r_q[WIDTH-1];
        end
`endif
        if (mode_is_left(mode_q)) begin
            r_step_d    = {r_q[WIDTH-2:0], fill_left};
            sout_step_d = r_q[WIDTH-1];
        end else begin
            r_step_d    = {fill_right, r_q[WIDTH-1:1]};
            sout_step_d = r_q[0];
        end
    end

    // Burst controller and datapath registers, outputs registered with the state
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            sout_q  <= 1'b0;
            mode_q  <= MODE_SHR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (enable) begin
            // Capture sees the register value from before this edge
            if (read) begin
                q_q <= r_q;
            end
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        r_q     <= d;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (start) begin
                        mode_q <= mode;
                        if (count != '0) begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_q    <= r_step_d;
                    sout_q <= sout_step_d;
                    if (cnt_zero) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : shiftreg_universal

// File: tb/tb_shiftreg_universal.sv
// Scoreboard bench for shiftreg_universal (WIDTH=4, COUNT_W=3). Stimulus pushes
// expected read values and expected done pulses into queues; monitors compare
// them against the DUT as the outputs appear.
module tb_shiftreg_universal;

    localparam int WIDTH   = 4;
    localparam int COUNT_W = 3;

    logic               clk = 1'b0;
    logic               clear;
    logic               enable;
    logic               load;
    logic [WIDTH-1:0]   d;
    logic               start;
    logic [COUNT_W-1:0] count;
    logic [1:0]         mode;
    logic               sin;
    logic               read;
    logic [WIDTH-1:0]   q;
    logic               sout;
    logic               busy;
    logic               done;

    shiftreg_universal #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk    (clk),
        .clear  (clear),
        .enable (enable),
        .load   (load),
        .d      (d),
        .start  (start),
        .count  (count),
        .mode   (mode),
        .sin    (sin),
        .read   (read),
        .q      (q),
        .sout   (sout),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   at_edge;
        logic sout;
        int   busy_cycles;
        int   width;
    } done_item_t;

    done_item_t       done_exp[$];
    logic [WIDTH-1:0] rd_exp[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Edge counter and per-edge flags seen by the monitor
    int   cyc = 0;
    logic rd_fire = 1'b0;
    logic clr_seen = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_fire  <= read && enable && !clear;
        clr_seen <= clear;
    end

    // Monitor: compares read captures and done pulses against the scoreboard
    int         busy_cnt  = 0;
    int         done_w    = 0;
    int         exp_width = 1;
    logic       done_prev = 1'b0;
    done_item_t it;
    logic [WIDTH-1:0] rexp;

    always @(negedge clk) begin
        if (clr_seen) busy_cnt = 0;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1 && !done_prev) begin
            if (done_exp.size() == 0) begin
                check("done_unexpected", 32'(done), 32'd0);
                exp_width = 1;
            end else begin
                it = done_exp.pop_front();
                check("done_edge", cyc, it.at_edge);
                check("done_sout", 32'(sout), 32'(it.sout));
                check("busy_cycles", busy_cnt, it.busy_cycles);
                exp_width = it.width;
            end
            busy_cnt = 0;
            done_w   = 0;
        end
        if (done === 1'b1) done_w++;
        if (done !== 1'b1 && done_prev) check("done_width", done_w, exp_width);
        done_prev = (done === 1'b1);

        if (rd_fire) begin
            if (rd_exp.size() == 0) begin
                check("read_unexpected", 32'(q), 32'hDEAD);
            end else begin
                rexp = rd_exp.pop_front();
                check("read_q", 32'(q), 32'(rexp));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_done(input int at_edge, input logic s, input int b, input int w);
        done_item_t x;
        x.at_edge     = at_edge;
        x.sout        = s;
        x.busy_cycles = b;
        x.width       = w;
        done_exp.push_back(x);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1;
        d    = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_read(input logic [WIDTH-1:0] e);
        read = 1'b1;
        rd_exp.push_back(e);
        tick();
        read = 1'b0;
    endtask

    task automatic do_start(input logic [COUNT_W-1:0] c, input logic [1:0] m, input logic s);
        start = 1'b1;
        count = c;
        mode  = m;
        sin   = s;
        tick();
        start = 1'b0;
    endtask

    int   k;
    logic [WIDTH-1:0] rot_r_exp;
    logic             rot_s_exp;

    initial begin
        clear = 1'b1; enable = 1'b1; load = 1'b0; d = '0; start = 1'b0;
        count = '0; mode = 2'b00; sin = 1'b0; read = 1'b0;

        // Reset state
        tick();
        clear = 1'b0;
        check("reset_q", 32'(q), 32'd0);
        check("reset_sout", 32'(sout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Load and read, including read+load returning the old value
        do_load(4'b1011);
        do_read(4'b1011);
        load = 1'b1; d = 4'b0110; read = 1'b1; rd_exp.push_back(4'b1011);
        tick();
        load = 1'b0; read = 1'b0;
        do_read(4'b0110);
        do_load(4'b1011);

        // Shift right by 2, sin=0: 1011 -> 0101 -> 0010, sout=1
        do_start(3'd2, 2'b00, 1'b0);
        k = cyc;
        push_done(k + 2, 1'b1, 2, 1);
        tick(3);
        do_read(4'b0010);

        // Rotate left by 5 (wrap) or plain shift left without rotate support
`ifdef SHIFTREG_ROTATE_EN
        rot_r_exp = 4'b0111; rot_s_exp = 1'b1;
`else
        rot_r_exp = 4'b0000; rot_s_exp = 1'b0;
`endif
        do_load(4'b1011);
        do_start(3'd5, 2'b11, 1'b0);
        k = cyc;
        push_done(k + 5, rot_s_exp, 5, 1);
        tick(6);
        do_read(rot_r_exp);

        // Shift left by 3 with sin=1 and a 2-cycle enable pause: 1011 -> 0111 -> 1111 -> 1111
        do_load(4'b1011);
        do_start(3'd3, 2'b01, 1'b1);
        k = cyc;
        push_done(k + 5, 1'b1, 5, 1);
        tick(1);
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(4);
        do_read(4'b1111);

        // Live sin sampling, mode changes mid-burst ignored: 0110 -> 1011 -> 0101 -> 1010 -> 1101
        do_load(4'b0110);
        do_start(3'd4, 2'b00, 1'b0);
        k = cyc;
        push_done(k + 4, 1'b0, 4, 1);
        sin = 1'b1; mode = 2'b01; tick();
        sin = 1'b0; tick();
        sin = 1'b1; tick();
        sin = 1'b1; tick();
        sin = 1'b0; mode = 2'b00; tick();
        do_read(4'b1101);

        // Zero count: done next cycle, stretched by one paused cycle, r unchanged
        do_start(3'd0, 2'b00, 1'b1);
        k = cyc;
        push_done(k, 1'b0, 0, 2);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick(2);
        do_read(4'b1101);

        // Load/start ignored during SHIFT, read captures intermediate: 1101 -> 0110 -> 0011 -> 0001
        do_start(3'd3, 2'b00, 1'b0);
        k = cyc;
        push_done(k + 3, 1'b1, 3, 1);
        tick();
        load = 1'b1; d = 4'b1111; start = 1'b1; count = 3'd0; read = 1'b1;
        rd_exp.push_back(4'b0110);
        tick();
        load = 1'b0; start = 1'b0; read = 1'b0;
        tick(2);
        do_read(4'b0001);

        // Back-to-back: start in the DONE cycle. 0001 -> 0011 (s0), then 0011 -> 0001 -> 0000 (s1)
        do_start(3'd1, 2'b01, 1'b1);
        k = cyc;
        push_done(k + 1, 1'b0, 1, 1);
        tick();
        do_start(3'd2, 2'b00, 1'b0);
        push_done(k + 4, 1'b1, 2, 1);
        tick(3);
        do_read(4'b0000);

        // Clear one edge into a 4-step burst: everything back to reset, no done
        do_load(4'b1111);
        do_read(4'b1111);
        do_start(3'd4, 2'b00, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_q", 32'(q), 32'd0);
        check("abort_sout", 32'(sout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick(5);
        check("abort_idle_busy", 32'(busy), 32'd0);
        do_read(4'b0000);

        tick(2);
        check("done_queue_drained", done_exp.size(), 32'd0);
        check("read_queue_drained", rd_exp.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shiftreg_universal
